mem_port_arbiter: RTL

//   Shares the single external memory port between the instruction-cache and data-cache miss engines.

---
 rtl/mem_port_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single external memory port between the I-cache and D-cache miss
// engines. One requester owns the port at a time and the arbiter walks a
// LINE_WORDS-beat line transfer (read or write) over the req/ack memory
// handshake, returning read words to the owner and pacing write words.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   i_req/i_addr           I-cache line-read request (held until i_done)
//   i_rdata/i_rvalid/i_done  read beats back to the I-cache
//   d_req/d_we/d_addr      D-cache line request; d_we sampled at grant
//   d_wdata/d_wnext        write word in / "word consumed, present next"
//   d_rdata/d_rvalid/d_done  read beats / end-of-transfer back to the D-cache
//   mem_req/mem_we/mem_addr/mem_wdata  memory request side
//   mem_ack/mem_rdata      one-cycle beat completion and read data
//   busy                   a line transfer is in progress
//   dbg_state              current FSM state (0 IDLE, 1 GRANT_I, 2 GRANT_D)
//
// Memory handshake: mem_req is held high with mem_addr/mem_we stable until
// the cycle in which mem_ack is high; that cycle completes the beat and the
// next beat (if any) is presented on the following cycle. mem_ack while the
// port is idle is ignored.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_rvalid,
  output logic                 i_done,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_wnext,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_rvalid,
  output logic                 d_done,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int BW = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [BW-1:0]             beat_q, beat_d;
  logic                      last_d_q, last_d_d;   // 1: D was the last owner
  logic [WORD_SIZE-BW-1:0]   base_q, base_d;       // line address without beat bits
  logic                      we_q, we_d;
  logic [WORD_SIZE-1:0]      i_rdata_q, i_rdata_d;
  logic                      i_rvalid_q, i_rvalid_d;
  logic                      i_done_q, i_done_d;
  logic [WORD_SIZE-1:0]      d_rdata_q, d_rdata_d;
  logic                      d_rvalid_q, d_rvalid_d;
  logic                      d_done_q, d_done_d;

  logic last_beat;
  logic grant_d;
  logic grant_i;

  // The beat bits of the request addresses are replaced by the beat counter.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[BW-1:0], d_addr[BW-1:0]};

  assign last_beat = (beat_q == BW'(LINE_WORDS - 1));

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    last_d_d   = last_d_q;
    base_d     = base_q;
    we_d       = we_q;
    i_rdata_d  = i_rdata_q;
    i_rvalid_d = 1'b0;
    i_done_d   = 1'b0;
    d_rdata_d  = d_rdata_q;
    d_rvalid_d = 1'b0;
    d_done_d   = 1'b0;
    grant_d    = 1'b0;
    grant_i    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Round-robin on contention: favour whoever did not own the port last.
        grant_d = d_req && (!i_req || !last_d_q);
        grant_i = i_req && !grant_d;
        if (grant_d) begin
          state_d  = ST_GRANT_D;
          last_d_d = 1'b1;
          base_d   = d_addr[WORD_SIZE-1:BW];
          we_d     = d_we;
          beat_d   = '0;
        end else if (grant_i) begin
          state_d  = ST_GRANT_I;
          last_d_d = 1'b0;
          base_d   = i_addr[WORD_SIZE-1:BW];
          we_d     = 1'b0;
          beat_d   = '0;
        end
      end

      ST_GRANT_I: begin
        if (mem_ack) begin
          beat_d     = beat_q + 1'b1;
          i_rdata_d  = mem_rdata;
          i_rvalid_d = 1'b1;
          if (last_beat) begin
            i_done_d = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end

      ST_GRANT_D: begin
        if (mem_ack) begin
          beat_d = beat_q + 1'b1;
          if (!we_q) begin
            d_rdata_d  = mem_rdata;
            d_rvalid_d = 1'b1;
          end
          if (last_beat) begin
            d_done_d = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      last_d_q   <= 1'b0;
      base_q     <= '0;
      we_q       <= 1'b0;
      i_rdata_q  <= '0;
      i_rvalid_q <= 1'b0;
      i_done_q   <= 1'b0;
      d_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
      d_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      last_d_q   <= last_d_d;
      base_q     <= base_d;
      we_q       <= we_d;
      i_rdata_q  <= i_rdata_d;
      i_rvalid_q <= i_rvalid_d;
      i_done_q   <= i_done_d;
      d_rdata_q  <= d_rdata_d;
      d_rvalid_q <= d_rvalid_d;
      d_done_q   <= d_done_d;
    end
  end

  // Memory side is a pure function of the registered state, so address and
  // write enable cannot move while a beat waits for its ack.
  assign mem_req   = (state_q != ST_IDLE);
  assign mem_addr  = mem_req ? {base_q, beat_q} : '0;
  assign mem_we    = (state_q == ST_GRANT_D) && we_q;
  assign mem_wdata = mem_we ? d_wdata : '0;
  assign d_wnext   = mem_we && mem_ack;
  assign busy      = mem_req;

  assign i_rdata   = i_rdata_q;
  assign i_rvalid  = i_rvalid_q;
  assign i_done    = i_done_q;
  assign d_rdata   = d_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_done    = d_done_q;
  assign dbg_state = state_q;

endmodule
